// File: rtl/sparse_pe_scheduler_if.sv
// sparse_pe_scheduler_if: operand handshake, encoder feed and accumulator strobes
// for one PE column scheduler. The master modport is the environment (operand FIFO
// plus encoder/PE). The slave modport is the scheduler.
interface sparse_pe_scheduler_if #(
    parameter int unsigned LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] cfg_len;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_en_multiplicand;
    logic [3:0]       in_sign;
    logic             encode_valid;
    logic [7:0]       en_multiplicand;
    logic [3:0]       sign_en_multiplicand;
    logic             pp_valid;
    logic             acc_clear;
    logic             dot_done;
    logic             busy;

    modport master (
        output start, cfg_len, in_valid, in_en_multiplicand, in_sign,
        input  in_ready, encode_valid, en_multiplicand, sign_en_multiplicand,
               pp_valid, acc_clear, dot_done, busy
    );

    modport slave (
        input  start, cfg_len, in_valid, in_en_multiplicand, in_sign,
        output in_ready, encode_valid, en_multiplicand, sign_en_multiplicand,
               pp_valid, acc_clear, dot_done, busy
    );
endinterface

// File: rtl/sparse_pe_scheduler.sv
// sparse_pe_scheduler: feeds one booth-encoded operand at a time to the sparse
// encoder. Each operand holds the encoder for max(nonzero digits, 1) slot cycles.
// Slot tags are delayed to line up with partial_product_index.
// Optional saturating perf counters are enabled by defining SPARSE_SCHED_PERF_EN.
module sparse_pe_scheduler #(
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned PIPE_D = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sparse_pe_scheduler_if.slave bus
`ifdef SPARSE_SCHED_PERF_EN
    ,
    output logic [31:0]          perf_ops,
    output logic [31:0]          perf_zero_ops,
    output logic [31:0]          perf_slots,
    output logic [31:0]          perf_stall
`endif
);
    localparam int unsigned SC_W = 3;
    localparam int unsigned FC_W = (PIPE_D > 1) ? $clog2(PIPE_D) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE0 = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [LEN_W-1:0]  rem_q;
    logic [SC_W-1:0]   sc_q;
    logic              first_q;
    logic [FC_W-1:0]   fc_q;
    logic [PIPE_D-1:0] valid_pipe_q;
    logic [PIPE_D-1:0] first_pipe_q;
    logic [PIPE_D-1:0] last_pipe_q;

    logic [SC_W-1:0]   nz;
    logic [SC_W-1:0]   slots;
    logic              in_run;
    logic              ready;
    logic              issue;
    logic              start_acc;
    logic              valid_tag;
    logic              first_tag;
    logic              last_tag;

    // Count the nonzero radix-4 digits of the presented operand. A zero operand still uses one slot.
    always_comb begin
        nz = '0;
        for (int i = 0; i < 4; i++) begin
            if (bus.in_en_multiplicand[2*i +: 2] != 2'b00) begin
                nz = nz + SC_W'(1);
            end
        end
        slots = (nz == '0) ? SC_W'(1) : nz;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = (bus.cfg_len == '0) ? S_DONE0 : S_RUN;
                end
            end
            S_RUN: begin
                if (last_tag) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (fc_q == FC_W'(PIPE_D - 1)) begin
                    state_d = S_IDLE;
                end
            end
            S_DONE0: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Handshake, encoder feed, issue-side slot tags and the delayed strobes
    always_comb begin
        in_run    = (state_q == S_RUN);
        start_acc = (state_q == S_IDLE) && bus.start;
        ready     = in_run && (rem_q != '0) && (sc_q <= SC_W'(1));
        issue     = bus.in_valid && ready;
        valid_tag = in_run && ((issue && (nz != '0)) || (sc_q >= SC_W'(2)));
        first_tag = issue && first_q;
        last_tag  = in_run && ((issue && (rem_q == LEN_W'(1)) && (slots == SC_W'(1))) ||
                               (!issue && (rem_q == '0) && (sc_q == SC_W'(2))));

        bus.in_ready             = ready;
        bus.encode_valid         = issue;
        bus.en_multiplicand      = bus.in_en_multiplicand;
        bus.sign_en_multiplicand = bus.in_sign;
        bus.busy                 = (state_q != S_IDLE);
        bus.pp_valid             = valid_pipe_q[PIPE_D-1];
        bus.acc_clear            = first_pipe_q[PIPE_D-1] || (state_q == S_DONE0);
        bus.dot_done             = last_pipe_q[PIPE_D-1] || (state_q == S_DONE0);
    end

    // Operand/slot counters, flush timer and the tag delay line matching encoder latency
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_q        <= '0;
            sc_q         <= '0;
            first_q      <= 1'b0;
            fc_q         <= '0;
            valid_pipe_q <= '0;
            first_pipe_q <= '0;
            last_pipe_q  <= '0;
        end else begin
            if (start_acc) begin
                rem_q   <= bus.cfg_len;
                sc_q    <= '0;
                first_q <= 1'b1;
            end else if (issue) begin
                rem_q   <= rem_q - LEN_W'(1);
                sc_q    <= slots;
                first_q <= 1'b0;
            end else if (sc_q != '0) begin
                sc_q    <= sc_q - SC_W'(1);
            end
            fc_q         <= (state_q == S_FLUSH) ? fc_q + FC_W'(1) : '0;
            valid_pipe_q <= (valid_pipe_q << 1) | PIPE_D'(valid_tag);
            first_pipe_q <= (first_pipe_q << 1) | PIPE_D'(first_tag);
            last_pipe_q  <= (last_pipe_q << 1) | PIPE_D'(last_tag);
        end
    end

`ifdef SPARSE_SCHED_PERF_EN
    logic slot_cyc;
    assign slot_cyc = in_run && (issue || (sc_q >= SC_W'(2)));

    // Saturating event counters, restarted by every accepted start
    always_ff @(posedge clk) begin
        if (!rst_n || start_acc) begin
            perf_ops      <= '0;
            perf_zero_ops <= '0;
            perf_slots    <= '0;
            perf_stall    <= '0;
        end else begin
            if (issue && (perf_ops != '1)) begin
                perf_ops <= perf_ops + 32'd1;
            end
            if (issue && (nz == '0) && (perf_zero_ops != '1)) begin
                perf_zero_ops <= perf_zero_ops + 32'd1;
            end
            if (slot_cyc && (perf_slots != '1)) begin
                perf_slots <= perf_slots + 32'd1;
            end
            if (ready && !bus.in_valid && (perf_stall != '1)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sparse_pe_scheduler.sv
// tb_sparse_pe_scheduler: directed and random dot products checked cycle by cycle
// against a timeline model built from operand digit counts and feed gaps.
module tb_sparse_pe_scheduler;
    localparam int unsigned LEN_W = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sparse_pe_scheduler_if #(.LEN_W(LEN_W)) bus ();

`ifdef SPARSE_SCHED_PERF_EN
    logic [31:0] perf_ops;
    logic [31:0] perf_zero_ops;
    logic [31:0] perf_slots;
    logic [31:0] perf_stall;
`endif

    sparse_pe_scheduler #(.LEN_W(LEN_W), .PIPE_D(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef SPARSE_SCHED_PERF_EN
        ,
        .perf_ops      (perf_ops),
        .perf_zero_ops (perf_zero_ops),
        .perf_slots    (perf_slots),
        .perf_stall    (perf_stall)
`endif
    );

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [7:0] ops  [64];
    int         gaps [64];

    function automatic int nz_of(input logic [7:0] m);
        int c = 0;
        for (int i = 0; i < 4; i++) begin
            if (((m >> (2 * i)) & 8'h03) != 8'h00) c++;
        end
        return c;
    endfunction

    function automatic int slots_of(input logic [7:0] m);
        return (nz_of(m) == 0) ? 1 : nz_of(m);
    endfunction

    function automatic logic [5:0] obs_vec();
        return {bus.busy, bus.in_ready, bus.encode_valid, bus.pp_valid, bus.acc_clear, bus.dot_done};
    endfunction

    task automatic check_vec(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b (busy,in_ready,encode_valid,pp_valid,acc_clear,dot_done)",
                   tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input longint obs, input longint exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One dot product of len operands from ops[] with gaps[k] idle feed cycles before operand k.
    task automatic run_dot(input int len, input bit poke, input string name, output int done_rel);
        int         issue [64];
        int         rdy, av, last, k, w;
        logic [5:0] expv [256];
        int         e_ops, e_zero, e_slots, e_stall;
        e_ops = len; e_zero = 0; e_slots = 0; e_stall = 0;
        for (int c = 0; c < 256; c++) expv[c] = '0;
        if (len == 0) begin
            last = 1;
            expv[1] = 6'b100011;
        end else begin
            for (int i = 0; i < len; i++) begin
                rdy = (i == 0) ? 1 : issue[i-1] + slots_of(ops[i-1]);
                av  = (i == 0) ? 1 : issue[i-1] + 1 + gaps[i];
                issue[i] = (rdy > av) ? rdy : av;
                for (int c = rdy; c <= issue[i]; c++) expv[c][4] = 1'b1;
                e_stall += issue[i] - rdy;
                expv[issue[i]][3] = 1'b1;
                for (int j = 0; j < nz_of(ops[i]); j++) expv[issue[i] + 2 + j][2] = 1'b1;
                if (nz_of(ops[i]) == 0) e_zero++;
                e_slots += slots_of(ops[i]);
            end
            expv[issue[0] + 2][1] = 1'b1;
            last = issue[len-1] + slots_of(ops[len-1]) + 1;
            expv[last][0] = 1'b1;
            for (int c = 1; c <= last; c++) expv[c][5] = 1'b1;
        end
        k = 0; w = 0; done_rel = -1;
        for (int rel = 0; rel <= last + 2; rel++) begin
            @(negedge clk);
            bus.start              = (rel == 0) || (poke && (rel == 3 || rel == last));
            bus.cfg_len            = (rel == 0) ? LEN_W'(len) : LEN_W'($urandom);
            bus.in_valid           = (k < len) && (w == 0);
            bus.in_en_multiplicand = (k < len) ? ops[k] : 8'h00;
            bus.in_sign            = 4'($urandom);
            #1;
            check_vec($sformatf("%s cyc%0d", name, rel), obs_vec(), expv[rel]);
            if (bus.in_valid) begin
                check_int($sformatf("%s passthru cyc%0d", name, rel),
                          {bus.sign_en_multiplicand, bus.en_multiplicand},
                          {bus.in_sign, bus.in_en_multiplicand});
            end
            if (bus.dot_done && done_rel < 0) done_rel = rel;
            if (bus.in_valid && bus.in_ready) begin
                k++;
                w = (k < len) ? gaps[k] : 0;
            end else if (w > 0) begin
                w--;
            end
        end
        @(negedge clk);
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
`ifdef SPARSE_SCHED_PERF_EN
        check_int({name, " perf_ops"},      perf_ops,      e_ops);
        check_int({name, " perf_zero_ops"}, perf_zero_ops, e_zero);
        check_int({name, " perf_slots"},    perf_slots,    e_slots);
        check_int({name, " perf_stall"},    perf_stall,    e_stall);
`endif
    endtask

    initial begin
        int         d_cont, d_gap, d_tmp, len;
        logic [7:0] m;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.cfg_len = '0; bus.in_valid = 1'b0;
        bus.in_en_multiplicand = '0; bus.in_sign = '0;
        for (int i = 0; i < 64; i++) gaps[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        check_vec("reset_state", obs_vec(), 6'b000000);
        @(negedge clk);
        rst_n = 1'b1;

        // single operand with three nonzero digits
        ops[0] = 8'b01_00_10_01;
        run_dot(1, 1'b0, "len1_nz3", d_tmp);

        // mixed density: four, zero, one nonzero digits
        ops[0] = 8'hFF; ops[1] = 8'h00; ops[2] = 8'h01;
        run_dot(3, 1'b0, "len3_mixed", d_tmp);
        check_int("len3_mixed done_cycle", d_tmp, 8);

        // empty dot product
        run_dot(0, 1'b0, "len0", d_tmp);
        check_int("len0 done_cycle", d_tmp, 1);

        // feed gap delays completion by exactly the gap
        ops[0] = 8'h01; ops[1] = 8'h04; ops[2] = 8'h40;
        run_dot(3, 1'b0, "feed_cont", d_cont);
        gaps[1] = 2;
        run_dot(3, 1'b0, "feed_gap", d_gap);
        gaps[1] = 0;
        check_int("gap_delay", d_gap - d_cont, 2);

        // start while busy (including on the dot_done cycle) is ignored
        ops[0] = 8'hFF; ops[1] = 8'h00; ops[2] = 8'h01;
        run_dot(3, 1'b1, "start_busy", d_tmp);

        // random operands, densities and feed gaps
        for (int r = 0; r < 8; r++) begin
            len = $urandom_range(1, 10);
            for (int i = 0; i < len; i++) begin
                m = '0;
                for (int d = 0; d < 4; d++) begin
                    if ($urandom_range(0, 1) == 1) m = m | (8'($urandom_range(0, 3)) << (2 * d));
                end
                ops[i]  = m;
                gaps[i] = $urandom_range(0, 2);
            end
            run_dot(len, r[0], $sformatf("rand%0d", r), d_tmp);
        end

        // reset in the middle of a dot product
        @(negedge clk);
        bus.start = 1'b1; bus.cfg_len = 8'd5; bus.in_valid = 1'b1; bus.in_en_multiplicand = 8'hFF;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_int("mid_run busy", bus.busy, 1);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_vec($sformatf("reset_mid cyc%0d", i), obs_vec(), 6'b000000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            check_vec($sformatf("post_reset cyc%0d", i), obs_vec(), 6'b000000);
        end

        // scheduler is usable again after the mid-run reset
        ops[0] = 8'h05; ops[1] = 8'hA0;
        run_dot(2, 1'b0, "after_reset", d_tmp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
